// File: rtl/ftdi_pkg.sv
// Shared types and default timing for the FT245-style FIFO bus arbiter.
package ftdi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_STROBE = 3'd1,
    WR_SETUP  = 3'd2,
    WR_STROBE = 3'd3,
    RECOVER   = 3'd4
  } state_t;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_t;

  localparam int RD_LOW_CYC_DEF   = 3;
  localparam int WR_SETUP_CYC_DEF = 1;
  localparam int WR_LOW_CYC_DEF   = 3;
  localparam int RECOV_CYC_DEF    = 4;
  localparam int BURST_MAX_DEF    = 16;
  localparam int CNT_W            = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ftdi_fifo_arbiter.sv
// Sequences FT245-style FIFO bus strobes and arbitrates between the host read
// path and the host write path with a bounded same-direction burst.
module ftdi_fifo_arbiter
  import ftdi_pkg::*;
#(
  parameter int RD_LOW_CYC   = RD_LOW_CYC_DEF,
  parameter int WR_SETUP_CYC = WR_SETUP_CYC_DEF,
  parameter int WR_LOW_CYC   = WR_LOW_CYC_DEF,
  parameter int RECOV_CYC    = RECOV_CYC_DEF,
  parameter int BURST_MAX    = BURST_MAX_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ftdi_rxf_n,
  input  logic       ftdi_txe_n,
  output logic       ftdi_rd_n,
  output logic       ftdi_wr_n,
  input  logic [7:0] adbus_in,
  output logic [7:0] adbus_out,
  output logic       adbus_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       bus_dir,
  output state_t     dbg_state
);

  // Handshakes: a byte moves on a rising clock edge where valid && ready.
  // rx side: rx_valid holds with rx_data until that edge. tx side: tx_data is
  // copied to the pad register on entry to WR_SETUP and tx_ready is high for
  // that one cycle, so the source may advance on the edge that ends it.

  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(WR_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(RECOV_CYC - 1);
  localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_MAX);

  logic rxf_s, txe_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_rxf_sync (
    .clock (clock),
    .reset (reset),
    .d     (ftdi_rxf_n),
    .q     (rxf_s)
  );

  sync_2ff #(.RESET_VAL(1'b1)) u_txe_sync (
    .clock (clock),
    .reset (reset),
    .d     (ftdi_txe_n),
    .q     (txe_s)
  );

  state_t           state, state_next;
  dir_t             dir_q, dir_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] burst_cnt, burst_next;
  logic             rd_ok, wr_ok;
  logic             start_rd, start_wr;

  always_comb begin
    rd_ok      = !rxf_s && !rx_valid;
    wr_ok      = !txe_s && tx_valid;
    state_next = state;
    dir_next   = dir_q;
    cnt_next   = cnt;
    burst_next = burst_cnt;
    start_rd   = 1'b0;
    start_wr   = 1'b0;

    case (state)
      IDLE: begin
        if (rd_ok && wr_ok) begin
          if (burst_cnt < BURST_LIM) begin
            start_rd = (dir_q == DIR_RD);
            start_wr = (dir_q == DIR_WR);
          end else begin
            start_rd = (dir_q == DIR_WR);
            start_wr = (dir_q == DIR_RD);
          end
        end else begin
          start_rd = rd_ok;
          start_wr = wr_ok;
        end

        if (start_rd || start_wr) begin
          dir_next = start_wr ? DIR_WR : DIR_RD;
          // A direction change restarts the burst with the byte being granted now.
          if (dir_next != dir_q)
            burst_next = CNT_W'(1);
          else if (burst_cnt < BURST_LIM)
            burst_next = burst_cnt + CNT_W'(1);
          cnt_next   = '0;
          state_next = start_wr ? WR_SETUP : RD_STROBE;
        end
      end

      RD_STROBE: begin
        if (cnt == RD_LAST) begin
          cnt_next   = '0;
          state_next = RECOVER;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      WR_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_next   = '0;
          state_next = WR_STROBE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      WR_STROBE: begin
        if (cnt == WR_LAST) begin
          cnt_next   = '0;
          state_next = RECOVER;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      RECOVER: begin
        if (cnt == RECOV_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      dir_q     <= DIR_RD;
      cnt       <= '0;
      burst_cnt <= '0;
      ftdi_rd_n <= 1'b1;
      ftdi_wr_n <= 1'b1;
      adbus_oe  <= 1'b0;
      adbus_out <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
    end else begin
      state     <= state_next;
      dir_q     <= dir_next;
      cnt       <= cnt_next;
      burst_cnt <= burst_next;
      // Pad strobes are registered from the next state so they never glitch.
      ftdi_rd_n <= (state_next != RD_STROBE);
      ftdi_wr_n <= (state_next != WR_STROBE);
      adbus_oe  <= (state_next == WR_SETUP) || (state_next == WR_STROBE) ||
                   ((state == WR_STROBE) && (state_next == RECOVER));
      tx_ready  <= start_wr;
      if (start_wr)
        adbus_out <= tx_data;
      if ((state == RD_STROBE) && (state_next == RECOVER)) begin
        rx_data  <= adbus_in;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign bus_dir   = (dir_q == DIR_WR);
  assign dbg_state = state;

endmodule

// File: tb/tb_ftdi_fifo_arbiter.sv
// Self-checking bench: FTDI chip model, tx source, rx/tx scoreboards, bus invariants.
module tb_ftdi_fifo_arbiter;
  import ftdi_pkg::*;

  localparam int RD_LOW  = 3;
  localparam int WR_LOW  = 3;
  localparam int RD_PER  = 8;
  localparam int WR_PER  = 9;
  localparam int BURST   = 16;

  logic       clock;
  logic       reset;
  logic       ftdi_rxf_n;
  logic       ftdi_txe_n;
  logic       ftdi_rd_n;
  logic       ftdi_wr_n;
  logic [7:0] adbus_in;
  logic [7:0] adbus_out;
  logic       adbus_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       bus_dir;
  state_t     dbg_state;

  ftdi_fifo_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .ftdi_rxf_n (ftdi_rxf_n),
    .ftdi_txe_n (ftdi_txe_n),
    .ftdi_rd_n  (ftdi_rd_n),
    .ftdi_wr_n  (ftdi_wr_n),
    .adbus_in   (adbus_in),
    .adbus_out  (adbus_out),
    .adbus_oe   (adbus_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .bus_dir    (bus_dir),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_bad = 0;
  int n_rd, n_wr, n_rx, n_txr, n_oe, rd_run, wr_run, cyc, rd_avail, cur_run;
  int overlap = 0, gap_bad = 0, txr_wide = 0, wr_unstable = 0;
  logic       prev_oe, prev_txr, post_wr, last_dir;
  logic [7:0] prev_out, host_byte;
  logic [7:0] rx_exp_q[$];
  logic [7:0] wr_exp_q[$];
  logic [7:0] tx_src_q[$];
  int rd_rise_q[$];
  int wr_rise_q[$];
  int runs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic log_dir(input logic d);
    if (d == last_dir) cur_run++;
    else begin
      runs.push_back(cur_run);
      cur_run  = 1;
      last_dir = d;
    end
  endtask

  task automatic clear_sb();
    rx_exp_q.delete(); wr_exp_q.delete(); tx_src_q.delete();
    rd_rise_q.delete(); wr_rise_q.delete(); runs.delete();
    n_rd = 0; n_wr = 0; n_rx = 0; n_txr = 0; n_oe = 0;
    host_byte = 8'h01; last_dir = 1'b0; cur_run = 0;
  endtask

  // driver tasks (called at a falling edge)
  task automatic tx_push(input logic [7:0] b);
    if (!tx_valid) begin
      tx_data = b;
      wr_exp_q.push_back(b);
      tx_valid = 1'b1;
    end else begin
      tx_src_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; tx_valid = 1'b0; ftdi_txe_n = 1'b1; rd_avail = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clear_sb();
  endtask

  // FTDI model, tx source and monitors; runs 2 time units after the falling
  // edge so it sees the values the next rising edge will sample.
  always @(negedge clock) begin
    #2;
    cyc++;
    ftdi_rxf_n = (rd_avail <= 0);
    if (reset) begin
      rd_run = 0; wr_run = 0; post_wr = 1'b0; prev_oe = 1'b0; prev_txr = 1'b0;
      adbus_in = 8'hEE;
    end else begin
      if (adbus_oe) n_oe++;
      if (!ftdi_rd_n && adbus_oe) overlap++;
      if (!ftdi_rd_n) begin
        rd_run++;
        if (rd_run == 1) begin
          if (prev_oe) gap_bad++;
          rx_exp_q.push_back(host_byte);
          adbus_in = 8'hEE;
        end else begin
          adbus_in = host_byte;
        end
      end else if (rd_run > 0) begin
        check("rd_low_cyc", 32'(rd_run), 32'(RD_LOW));
        rd_run = 0; n_rd++; rd_rise_q.push_back(cyc);
        adbus_in = 8'hEE; host_byte++; rd_avail--;
        log_dir(1'b0);
      end

      if (post_wr) begin
        check("wr_oe_release", 32'(adbus_oe), 32'd0);
        post_wr = 1'b0;
      end
      if (!ftdi_wr_n) begin
        if (wr_run == 0) begin
          check("wr_expected", 32'(wr_exp_q.size() > 0), 32'd1);
          check("wr_setup_oe", 32'(prev_oe), 32'd1);
          if (wr_exp_q.size() > 0) check("wr_setup_data", 32'(prev_out), 32'(wr_exp_q[0]));
        end
        wr_run++;
        if (!adbus_oe || (wr_exp_q.size() > 0 && adbus_out !== wr_exp_q[0])) wr_unstable++;
      end else if (wr_run > 0) begin
        check("wr_low_cyc", 32'(wr_run), 32'(WR_LOW));
        check("wr_rise_oe", 32'(adbus_oe), 32'd1);
        if (wr_exp_q.size() > 0) check("wr_data", 32'(adbus_out), 32'(wr_exp_q.pop_front()));
        wr_run = 0; n_wr++; wr_rise_q.push_back(cyc); post_wr = 1'b1;
        log_dir(1'b1);
      end

      if (tx_ready && prev_txr) txr_wide++;
      if (tx_valid && tx_ready) begin
        n_txr++;
        if (tx_src_q.size() > 0) begin
          tx_data = tx_src_q.pop_front();
          wr_exp_q.push_back(tx_data);
        end else begin
          tx_valid = 1'b0;
        end
      end

      if (rx_valid && rx_ready) begin
        check("rx_expected", 32'(rx_exp_q.size() > 0), 32'd1);
        if (rx_exp_q.size() > 0) check("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
        n_rx++;
      end

      prev_oe = adbus_oe; prev_out = adbus_out; prev_txr = tx_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    ftdi_txe_n = 1'b1; ftdi_rxf_n = 1'b1; rd_avail = 0; adbus_in = 8'hEE;
    cyc = 0; rd_run = 0; wr_run = 0;
    clear_sb();
    repeat (3) @(negedge clock);
    check("rst_rd_n", 32'(ftdi_rd_n), 32'd1);
    check("rst_wr_n", 32'(ftdi_wr_n), 32'd1);
    check("rst_oe", 32'(adbus_oe), 32'd0);
    check("rst_out", 32'(adbus_out), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_bus_dir", 32'(bus_dir), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    clear_sb();

    // 1: five host bytes read back in order at full rate, never driving ADBUS
    rd_avail = 5;
    for (int i = 0; i < 300 && n_rx < 5; i++) @(negedge clock);
    check("t1_timeout", 32'(n_rx == 5), 32'd1);
    repeat (20) @(negedge clock);
    check("t1_rd_count", 32'(n_rd), 32'd5);
    check("t1_oe_never", 32'(n_oe), 32'd0);
    check("t1_rx_left", 32'(rx_exp_q.size()), 32'd0);
    for (int i = 1; i < rd_rise_q.size(); i++)
      check("t1_rd_period", 32'(rd_rise_q[i] - rd_rise_q[i-1]), 32'(RD_PER));

    // 2: three writes
    do_reset();
    ftdi_txe_n = 1'b0;
    tx_push(8'hA5); tx_push(8'h5A); tx_push(8'hFF);
    for (int i = 0; i < 300 && n_wr < 3; i++) @(negedge clock);
    check("t2_timeout", 32'(n_wr == 3), 32'd1);
    repeat (20) @(negedge clock);
    check("t2_wr_count", 32'(n_wr), 32'd3);
    check("t2_tx_ready_count", 32'(n_txr), 32'd3);
    check("t2_wr_left", 32'(wr_exp_q.size()), 32'd0);
    check("t2_bus_dir", 32'(bus_dir), 32'd1);
    for (int i = 1; i < wr_rise_q.size(); i++)
      check("t2_wr_period", 32'(wr_rise_q[i] - wr_rise_q[i-1]), 32'(WR_PER));

    // 3: both directions always eligible -> alternating bursts
    do_reset();
    rx_ready = 1'b1; rd_avail = 1000; ftdi_txe_n = 1'b0;
    for (int i = 0; i < 70; i++) tx_push(8'($urandom_range(0, 255)));
    for (int i = 0; i < 3000 && runs.size() < 3; i++) @(negedge clock);
    check("t3_timeout", 32'(runs.size() >= 3), 32'd1);
    if (runs.size() >= 3) begin
      check("t3_run0_reads", 32'(runs[0]), 32'(BURST));
      check("t3_run1_writes", 32'(runs[1]), 32'(BURST));
      check("t3_run2_reads", 32'(runs[2]), 32'(BURST));
    end

    // 4: consumer stall blocks further reads
    do_reset();
    rx_ready = 1'b0; rd_avail = 3;
    for (int i = 0; i < 100 && !rx_valid; i++) @(negedge clock);
    check("t4_timeout_valid", 32'(rx_valid), 32'd1);
    repeat (40) @(negedge clock);
    check("t4_single_read", 32'(n_rd), 32'd1);
    check("t4_valid_held", 32'(rx_valid), 32'd1);
    check("t4_data_held", 32'(rx_data), 32'h01);
    rx_ready = 1'b1;
    for (int i = 0; i < 30 && n_rd < 2; i++) @(negedge clock);
    check("t4_resume", 32'(n_rd >= 2), 32'd1);
    for (int i = 0; i < 100 && n_rx < 3; i++) @(negedge clock);
    check("t4_rx_count", 32'(n_rx), 32'd3);

    // 5: reset during second low cycle of a write strobe
    do_reset();
    ftdi_txe_n = 1'b0;
    tx_push(8'h96);
    for (int i = 0; i < 50 && dbg_state != WR_STROBE; i++) @(negedge clock);
    check("t5_reach_strobe", 32'(dbg_state), 32'(WR_STROBE));
    @(negedge clock);
    check("t5_pre_wr_n", 32'(ftdi_wr_n), 32'd0);
    reset = 1'b1; tx_valid = 1'b0; ftdi_txe_n = 1'b1;
    @(negedge clock);
    check("t5_wr_n", 32'(ftdi_wr_n), 32'd1);
    check("t5_oe", 32'(adbus_oe), 32'd0);
    check("t5_tx_ready", 32'(tx_ready), 32'd0);
    check("t5_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    clear_sb();

    // 6: both status flags inactive
    do_reset();
    rd_avail = 0; ftdi_txe_n = 1'b1;
    tx_push(8'h3C);
    repeat (1000) @(negedge clock);
    check("t6_no_rd", 32'(n_rd), 32'd0);
    check("t6_no_wr", 32'(n_wr), 32'd0);
    check("t6_no_tx_ready", 32'(n_txr), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(IDLE));

    check("no_rd_oe_overlap", 32'(overlap), 32'd0);
    check("oe_gap_before_read", 32'(gap_bad), 32'd0);
    check("tx_ready_single", 32'(txr_wide), 32'd0);
    check("wr_bus_stable", 32'(wr_unstable), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
